yolo_control_unit: RTL and testbench
====================================

Name: yolo_control_unit

Overview:
- Top-level sequencer for the YOLO inference datapath.
- Starts automatically after reset and steps through the stage order: input fetch, then NUM_LAYERS repetitions of convolution → activation → pooling, then fully-connected, then detection.
- Drives exactly one stage-enable at a time; each stage's duration is a fixed, parameterised cycle count.
- Has no start/ack inputs; downstream blocks simply act while their enable is high.

Parameters:
- FETCH_CYCLES, 4, cycles fetch_input stays high (≥1)
- CONV_CYCLES, 8, cycles per conv stage (≥1)
- ACT_CYCLES, 2, cycles per activation stage (≥1)
- POOL_CYCLES, 4, cycles per pooling stage (≥1)
- FC_CYCLES, 6, cycles of fc stage (≥1)
- DETECT_CYCLES, 3, cycles of detect stage (≥1)
- NUM_LAYERS, 2, conv/act/pool repetitions (≥1)
- CNT_W, 16, width of the stage cycle counter; must hold max(*_CYCLES)-1

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- fetch_input  output  1  input-fetch stage enable
- conv_enable  output  1  convolution stage enable
- pool_enable  output  1  pooling stage enable
- activation_enable  output  1  activation stage enable
- fc_enable  output  1  fully-connected stage enable
- detect_enable  output  1  detection stage enable
- busy  output  1  high in any stage state (FETCH..DETECT)
- frame_done  output  1  high while in DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- States: IDLE, FETCH, CONV, ACT, POOL, FC, DETECT, DONE.
- Reset (rst_n=0 sampled at a clk edge):
  - state←IDLE, stage counter←0, layer counter←0.
  - All outputs are decoded from state, so all are 0.
  - Reset mid-operation aborts immediately with the same result.
- Outputs are a pure decode of the registered state (Moore); no combinational path from rst_n to the outputs.
  - One-hot: at most one enable high in any cycle; none in IDLE or DONE.
- IDLE lasts exactly one cycle: the first edge with rst_n=1 moves to FETCH.
- Stage counter:
  - Cleared on entry to every stage state; increments each cycle in that state.
  - The state exits when counter == STAGE_CYCLES-1, so each stage is high for exactly STAGE_CYCLES consecutive cycles.
- Transitions:
  - FETCH→CONV
  - CONV→ACT
  - ACT→POOL
  - POOL→CONV if layer counter < NUM_LAYERS-1 (layer counter increments on this transition), else →FC
  - FC→DETECT
  - DETECT→DONE
- Layer counter clears on entry to FETCH.
- No idle gaps between stages; a new enable rises on the same edge the previous one falls.
- DONE behaviour is set by the optional feature (below).
- Defaults, counting edge 1 as the first edge after reset release:
  - FETCH: after edges 1–4
  - CONV0: 5–12; ACT0: 13–14; POOL0: 15–18
  - CONV1: 19–26; ACT1: 27–28; POOL1: 29–32
  - FC: 33–38; DETECT: 39–41
  - DONE: from edge 42
- Total frame length = FETCH + NUM_LAYERS·(CONV+ACT+POOL) + FC + DETECT cycles.

Optional Feature:
- Macro: CTRL_FRAME_LOOP_EN.
- Defined: DONE lasts exactly one cycle (frame_done pulses for 1 cycle), then FETCH; the sequence repeats indefinitely.
- Undefined: DONE is terminal. frame_done stays high and all enables stay 0 until rst_n is asserted.

Test Plan:
- Reset held 1 cycle, then released:
  - While rst_n=0, all six enables, busy and frame_done = 0.
  - After edge 1, fetch_input=1, busy=1.
- Defaults, 20 edges after release → conv_enable=1; fetch_input, pool_enable, activation_enable, fc_enable, detect_enable = 0.
- Defaults, per-edge monitor over the full frame:
  - Enable durations are 4, 8/2/4 per layer (×2), 6, 3.
  - Exactly one enable high on edges 1–41; frame_done=1 after edge 42.
- Macro undefined, run 100 cycles → frame_done stays 1 and all enables stay 0 from edge 42 onward.
- Macro defined:
  - frame_done high for exactly 1 cycle (after edge 42).
  - fetch_input=1 after edge 43; the second frame's timing is identical to the first.
- Reset asserted after edge 22 (during CONV1), then released:
  - Next cycle all outputs = 0.
  - Sequence restarts from FETCH, full 4-cycle fetch, with layer count starting again at layer 0.

Source files
------------

// File: rtl/yolo_control_unit.sv
// Fixed-schedule sequencer for the YOLO inference datapath: fetch, NUM_LAYERS x (conv, act, pool),
// fc, detect, done. Optional macro CTRL_FRAME_LOOP_EN makes DONE a one-cycle pulse before refetch.
module yolo_control_unit #(
  parameter int unsigned FETCH_CYCLES  = 4,
  parameter int unsigned CONV_CYCLES   = 8,
  parameter int unsigned ACT_CYCLES    = 2,
  parameter int unsigned POOL_CYCLES   = 4,
  parameter int unsigned FC_CYCLES     = 6,
  parameter int unsigned DETECT_CYCLES = 3,
  parameter int unsigned NUM_LAYERS    = 2,
  parameter int unsigned CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic fetch_input,
  output logic conv_enable,
  output logic pool_enable,
  output logic activation_enable,
  output logic fc_enable,
  output logic detect_enable,
  output logic busy,
  output logic frame_done
);

  localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StConv,
    StAct,
    StPool,
    StFc,
    StDetect,
    StDone
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_d;
  logic [CNT_W-1:0]   w_stage_last;
  logic [LAYER_W-1:0] r_layer;
  logic [LAYER_W-1:0] w_layer_d;
  logic               w_cnt_done;
  logic               w_more_layers;

  always_comb begin
    w_stage_last = '0;
    case (r_state)
      StFetch:  w_stage_last = CNT_W'(FETCH_CYCLES - 1);
      StConv:   w_stage_last = CNT_W'(CONV_CYCLES - 1);
      StAct:    w_stage_last = CNT_W'(ACT_CYCLES - 1);
      StPool:   w_stage_last = CNT_W'(POOL_CYCLES - 1);
      StFc:     w_stage_last = CNT_W'(FC_CYCLES - 1);
      StDetect: w_stage_last = CNT_W'(DETECT_CYCLES - 1);
      default:  w_stage_last = '0;
    endcase
  end

  assign w_cnt_done    = (r_cnt == w_stage_last);
  assign w_more_layers = (r_layer < LAYER_W'(NUM_LAYERS - 1));

  // The counter wraps to zero on the exit cycle, so every new stage starts counting from zero.
  always_comb begin
    w_state_d = r_state;
    w_layer_d = r_layer;
    w_cnt_d   = w_cnt_done ? '0 : r_cnt + 1'b1;
    case (r_state)
      StIdle: begin
        w_state_d = StFetch;
        w_cnt_d   = '0;
        w_layer_d = '0;
      end
      StFetch: begin
        if (w_cnt_done) w_state_d = StConv;
      end
      StConv: begin
        if (w_cnt_done) w_state_d = StAct;
      end
      StAct: begin
        if (w_cnt_done) w_state_d = StPool;
      end
      StPool: begin
        if (w_cnt_done) begin
          if (w_more_layers) begin
            w_state_d = StConv;
            w_layer_d = r_layer + 1'b1;
          end else begin
            w_state_d = StFc;
          end
        end
      end
      StFc: begin
        if (w_cnt_done) w_state_d = StDetect;
      end
      StDetect: begin
        if (w_cnt_done) w_state_d = StDone;
      end
      StDone: begin
        w_cnt_d = '0;
`ifdef CTRL_FRAME_LOOP_EN
        w_state_d = StFetch;
        w_layer_d = '0;
`else
        w_state_d = StDone;
`endif
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
        w_layer_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they always equal a decode of r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= StIdle;
      r_cnt             <= '0;
      r_layer           <= '0;
      fetch_input       <= 1'b0;
      conv_enable       <= 1'b0;
      activation_enable <= 1'b0;
      pool_enable       <= 1'b0;
      fc_enable         <= 1'b0;
      detect_enable     <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      r_state           <= w_state_d;
      r_cnt             <= w_cnt_d;
      r_layer           <= w_layer_d;
      fetch_input       <= (w_state_d == StFetch);
      conv_enable       <= (w_state_d == StConv);
      activation_enable <= (w_state_d == StAct);
      pool_enable       <= (w_state_d == StPool);
      fc_enable         <= (w_state_d == StFc);
      detect_enable     <= (w_state_d == StDetect);
      busy              <= (w_state_d != StIdle) && (w_state_d != StDone);
      frame_done        <= (w_state_d == StDone);
    end
  end

endmodule

// File: tb/tb_yolo_control_unit.sv
// Scoreboard bench for yolo_control_unit: a schedule model predicts every cycle's outputs from
// the count of edges since reset release; a negedge monitor compares. Honours CTRL_FRAME_LOOP_EN.
module tb_yolo_control_unit;

  localparam int FETCH  = 4;
  localparam int CONV   = 8;
  localparam int ACT    = 2;
  localparam int POOL   = 4;
  localparam int FC     = 6;
  localparam int DETECT = 3;
  localparam int LAYERS = 2;
  localparam int FRAME  = FETCH + LAYERS * (CONV + ACT + POOL) + FC + DETECT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fetch_input, conv_enable, pool_enable, activation_enable;
  logic fc_enable, detect_enable, busy, frame_done;

  always #5 clk = ~clk;

  yolo_control_unit #(
    .FETCH_CYCLES (FETCH),
    .CONV_CYCLES  (CONV),
    .ACT_CYCLES   (ACT),
    .POOL_CYCLES  (POOL),
    .FC_CYCLES    (FC),
    .DETECT_CYCLES(DETECT),
    .NUM_LAYERS   (LAYERS),
    .CNT_W        (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_input      (fetch_input),
    .conv_enable      (conv_enable),
    .pool_enable      (pool_enable),
    .activation_enable(activation_enable),
    .fc_enable        (fc_enable),
    .detect_enable    (detect_enable),
    .busy             (busy),
    .frame_done       (frame_done)
  );

  // Vector layout: {busy, frame_done, fetch, conv, act, pool, fc, detect}
  localparam logic [7:0] V_FETCH  = 8'b1010_0000;
  localparam logic [7:0] V_CONV   = 8'b1001_0000;
  localparam logic [7:0] V_ACT    = 8'b1000_1000;
  localparam logic [7:0] V_POOL   = 8'b1000_0100;
  localparam logic [7:0] V_FC     = 8'b1000_0010;
  localparam logic [7:0] V_DETECT = 8'b1000_0001;
  localparam logic [7:0] V_DONE   = 8'b0100_0000;

  typedef struct {
    int         k;
    logic [7:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drv_done = 1'b0;

  // k = edges since release (0 = the IDLE cycle right after reset).
  function automatic logic [7:0] model(int k);
    int j;
    if (k == 0) return 8'h00;
    j = k - 1;
`ifdef CTRL_FRAME_LOOP_EN
    j = j % (FRAME + 1);
`endif
    if (j >= FRAME) return V_DONE;
    if (j < FETCH) return V_FETCH;
    j -= FETCH;
    for (int l = 0; l < LAYERS; l++) begin
      if (j < CONV) return V_CONV;
      j -= CONV;
      if (j < ACT) return V_ACT;
      j -= ACT;
      if (j < POOL) return V_POOL;
      j -= POOL;
    end
    if (j < FC) return V_FC;
    j -= FC;
    return V_DETECT;
  endfunction

  int k_since = -1;

  task automatic step(input logic rst_val);
    exp_t e;
    @(negedge clk);
    rst_n = rst_val;
    @(posedge clk);
    if (!rst_val) k_since = 0;
    else if (k_since >= 0) k_since++;
    e.k   = rst_val ? k_since : -1;
    e.vec = rst_val ? model(k_since) : 8'h00;
    exp_q.push_back(e);
  endtask

  task automatic run_episode(input int hold, input int run);
    for (int i = 0; i < hold; i++) step(1'b0);
    for (int i = 0; i < run; i++) step(1'b1);
  endtask

  initial begin
    run_episode(1, 22);   // reset lands during CONV1
    run_episode(1, 100);  // full frame plus the DONE tail or second frame
    for (int ep = 0; ep < 10; ep++)
      run_episode(int'($urandom_range(1, 3)), int'($urandom_range(1, 130)));
    @(negedge clk);
    @(negedge clk);
    drv_done = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {busy, frame_done, fetch_input, conv_enable, activation_enable, pool_enable,
             fc_enable, detect_enable};
      n_checks++;
      if (act !== e.vec) begin
        n_fail++;
        $display("FAIL outputs k=%0d: got %b, expected %b", e.k, act, e.vec);
      end
    end
  end

  initial begin
    wait (drv_done);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
